// File: rtl/regfile_pkg.sv
// Shared encodings and helpers for the parametrised register file.
// Write-source select values and an address range check used by the top and the scoreboard.
package regfile_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_MOVE = 2'b01,
        SRC_OR   = 2'b10,
        SRC_ALU  = 2'b11
    } src_sel_e;

    localparam int MIN_REGS = 2;
    localparam int MAX_REGS = 32;

    function automatic src_sel_e decode_src(input logic [1:0] sel);
        return src_sel_e'(sel);
    endfunction

    // Address fields are $clog2 wide, so a non-power-of-2 file has unmapped codes.
    function automatic logic addr_ok(input int addr, input int num_regs);
        return (addr >= 0) && (addr < num_regs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set by a reservation, cleared by a write.
// REGFILE_BYPASS_EN selects whether the busy lookup sees the post-edge or pre-edge bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              busy_a,
    output logic              busy_b
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_next;
    logic [NUM_REGS-1:0] pend_view;

    // Set is applied after clear so a same-address reserve stays outstanding.
    always_comb begin
        pend_next = pend;
        if (clr_en && addr_ok(int'(clr_addr), NUM_REGS)) begin
            pend_next[clr_addr] = 1'b0;
        end
        if (rsv_en && addr_ok(int'(rsv_addr), NUM_REGS)) begin
            pend_next[rsv_addr] = 1'b1;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign pend_view = pend_next;
`else
    assign pend_view = pend;
`endif

    assign busy_a = addr_ok(int'(rd_addr_a), NUM_REGS) && pend_view[rd_addr_a];
    assign busy_b = addr_ok(int'(rd_addr_b), NUM_REGS) && pend_view[rd_addr_b];

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: source mux, storage, two registered read ports and sticky err.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data/pend state to the read ports.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int NUM_REGS = 8,
    parameter  int ZERO_R0  = 0,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] OR2,
    input  logic [DATA_W-1:0] ALU_IN,
    input  logic [1:0]        mux_sel,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] mv_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DATA_W-1:0] dataout_A,
    output logic [DATA_W-1:0] dataout_B,
    output logic              busy_A,
    output logic              busy_B,
    output logic              err
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    src_sel_e          src;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_store;
    logic              err_set;
    logic [DATA_W-1:0] rd_val_a;
    logic [DATA_W-1:0] rd_val_b;
    logic              busy_a_now;
    logic              busy_b_now;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    function automatic logic [DATA_W-1:0] read_reg(input logic [ADDR_W-1:0] a);
        if (!addr_ok(int'(a), NUM_REGS) || is_zero_reg(a)) begin
            return '0;
        end
        return regs[a];
    endfunction

    assign src = decode_src(mux_sel);

    always_comb begin
        wr_data = '0;
        case (src)
            SRC_MOVE: wr_data = read_reg(mv_addr);
            SRC_OR:   wr_data = OR2;
            SRC_ALU:  wr_data = ALU_IN;
            default:  wr_data = '0;
        endcase
    end

    // A write to a hardwired r0 still completes (retires its reservation) but stores nothing.
    assign wr_valid = wr_en && (src != SRC_NONE) && addr_ok(int'(wr_addr), NUM_REGS);
    assign wr_store = wr_valid && !is_zero_reg(wr_addr);
    assign err_set  = wr_en && ((src == SRC_NONE) || !addr_ok(int'(wr_addr), NUM_REGS));

`ifdef REGFILE_BYPASS_EN
    assign rd_val_a = (wr_store && (rd_addr_a == wr_addr)) ? wr_data : read_reg(rd_addr_a);
    assign rd_val_b = (wr_store && (rd_addr_b == wr_addr)) ? wr_data : read_reg(rd_addr_b);
`else
    assign rd_val_a = read_reg(rd_addr_a);
    assign rd_val_b = read_reg(rd_addr_b);
`endif

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .clr_en    (wr_valid),
        .clr_addr  (wr_addr),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .busy_a    (busy_a_now),
        .busy_b    (busy_b_now)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            dataout_A <= '0;
            dataout_B <= '0;
            busy_A    <= 1'b0;
            busy_B    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (wr_store) begin
                regs[wr_addr] <= wr_data;
            end
            if (err_set) begin
                err <= 1'b1;
            end
            if (rd_en) begin
                dataout_A <= rd_val_a;
                dataout_B <= rd_val_b;
                busy_A    <= busy_a_now;
                busy_B    <= busy_b_now;
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a 10-register instance and an 8-register ZERO_R0 instance,
// both checked every cycle against a state-level model plus directed literal checks.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        bit       rst;
        bit [7:0] or2;
        bit [7:0] alu;
        bit [1:0] sel;
        bit       wr_en;
        int       wr_addr;
        int       mv_addr;
        bit       rd_en;
        int       ra;
        int       rb;
        bit       rsv_en;
        int       rsv_addr;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_wr_en, a_rd_en, a_rsv_en;
    logic [7:0] a_or2, a_alu;
    logic [1:0] a_sel;
    logic [3:0] a_wr_addr, a_mv_addr, a_ra, a_rb, a_rsv_addr;
    logic [7:0] a_da, a_db;
    logic       a_ba, a_bb, a_err;

    logic       z_rst, z_wr_en, z_rd_en, z_rsv_en;
    logic [7:0] z_or2, z_alu;
    logic [1:0] z_sel;
    logic [2:0] z_wr_addr, z_mv_addr, z_ra, z_rb, z_rsv_addr;
    logic [7:0] z_da, z_db;
    logic       z_ba, z_bb, z_err;

    regfile_param #(.DATA_W(8), .NUM_REGS(10), .ZERO_R0(0)) dut_a (
        .clk(clk), .rst(a_rst), .OR2(a_or2), .ALU_IN(a_alu), .mux_sel(a_sel),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .mv_addr(a_mv_addr), .rd_en(a_rd_en),
        .rd_addr_a(a_ra), .rd_addr_b(a_rb), .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
        .dataout_A(a_da), .dataout_B(a_db), .busy_A(a_ba), .busy_B(a_bb), .err(a_err)
    );

    regfile_param #(.DATA_W(8), .NUM_REGS(8), .ZERO_R0(1)) dut_z (
        .clk(clk), .rst(z_rst), .OR2(z_or2), .ALU_IN(z_alu), .mux_sel(z_sel),
        .wr_en(z_wr_en), .wr_addr(z_wr_addr), .mv_addr(z_mv_addr), .rd_en(z_rd_en),
        .rd_addr_a(z_ra), .rd_addr_b(z_rb), .rsv_en(z_rsv_en), .rsv_addr(z_rsv_addr),
        .dataout_A(z_da), .dataout_B(z_db), .busy_A(z_ba), .busy_B(z_bb), .err(z_err)
    );

    stim_t    s [2];
    bit [7:0] m_reg  [2][32];
    bit       m_pend [2][32];
    bit       m_err [2];
    bit [7:0] m_da [2];
    bit [7:0] m_db [2];
    bit       m_ba [2];
    bit       m_bb [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t t;
        t.rst = 0; t.or2 = 0; t.alu = 0; t.sel = 0; t.wr_en = 0; t.wr_addr = 0;
        t.mv_addr = 0; t.rd_en = 0; t.ra = 0; t.rb = 0; t.rsv_en = 0; t.rsv_addr = 0;
        return t;
    endfunction

    function automatic stim_t rnd(input int nr, input int amax, input bit allow_rst);
        stim_t t;
        t.rst      = allow_rst && ($urandom_range(0, 79) == 0);
        t.or2      = 8'($urandom);
        t.alu      = 8'($urandom);
        t.sel      = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        t.wr_en    = ($urandom_range(0, 3) != 0);
        t.wr_addr  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, amax) : $urandom_range(0, nr - 1);
        t.mv_addr  = $urandom_range(0, amax);
        t.rd_en    = ($urandom_range(0, 3) != 0);
        t.ra       = $urandom_range(0, amax);
        t.rb       = ($urandom_range(0, 3) == 0) ? t.wr_addr : $urandom_range(0, amax);
        t.rsv_en   = ($urandom_range(0, 2) == 0);
        t.rsv_addr = ($urandom_range(0, 2) == 0) ? t.wr_addr : $urandom_range(0, amax);
        return t;
    endfunction

    task automatic apply();
        a_rst = s[0].rst; a_or2 = s[0].or2; a_alu = s[0].alu; a_sel = s[0].sel;
        a_wr_en = s[0].wr_en; a_wr_addr = 4'(s[0].wr_addr); a_mv_addr = 4'(s[0].mv_addr);
        a_rd_en = s[0].rd_en; a_ra = 4'(s[0].ra); a_rb = 4'(s[0].rb);
        a_rsv_en = s[0].rsv_en; a_rsv_addr = 4'(s[0].rsv_addr);
        z_rst = s[1].rst; z_or2 = s[1].or2; z_alu = s[1].alu; z_sel = s[1].sel;
        z_wr_en = s[1].wr_en; z_wr_addr = 3'(s[1].wr_addr); z_mv_addr = 3'(s[1].mv_addr);
        z_rd_en = s[1].rd_en; z_ra = 3'(s[1].ra); z_rb = 3'(s[1].rb);
        z_rsv_en = s[1].rsv_en; z_rsv_addr = 3'(s[1].rsv_addr);
    endtask

    // What a read of address a returns given a register image.
    function automatic bit [7:0] view(input int a, input int nr, input bit z0, input bit [7:0] img [32]);
        if (a >= nr || (z0 && a == 0)) return 8'h00;
        return img[a];
    endfunction

    task automatic model_step(input int i);
        int       nr;
        bit       z0, wr_ok;
        bit [7:0] data;
        bit [7:0] oreg [32];
        bit [7:0] nreg [32];
        bit       opend [32];
        bit       npend [32];
        nr = (i == 0) ? 10 : 8;
        z0 = (i == 1);
        if (s[i].rst) begin
            for (int k = 0; k < 32; k++) begin
                m_reg[i][k] = 0;
                m_pend[i][k] = 0;
            end
            m_err[i] = 0; m_da[i] = 0; m_db[i] = 0; m_ba[i] = 0; m_bb[i] = 0;
            return;
        end
        for (int k = 0; k < 32; k++) begin
            oreg[k] = m_reg[i][k]; nreg[k] = m_reg[i][k];
            opend[k] = m_pend[i][k]; npend[k] = m_pend[i][k];
        end
        wr_ok = s[i].wr_en && s[i].sel != 0 && s[i].wr_addr < nr;
        case (s[i].sel)
            2'd1:    data = view(s[i].mv_addr, nr, z0, oreg);
            2'd2:    data = s[i].or2;
            default: data = s[i].alu;
        endcase
        if (s[i].wr_en && (s[i].sel == 0 || s[i].wr_addr >= nr)) m_err[i] = 1;
        if (wr_ok && !(z0 && s[i].wr_addr == 0)) nreg[s[i].wr_addr] = data;
        if (wr_ok) npend[s[i].wr_addr] = 0;
        if (s[i].rsv_en && s[i].rsv_addr < nr) npend[s[i].rsv_addr] = 1;
        if (s[i].rd_en) begin
            if (BYP) begin
                m_da[i] = view(s[i].ra, nr, z0, nreg);
                m_db[i] = view(s[i].rb, nr, z0, nreg);
                m_ba[i] = (s[i].ra < nr) && npend[s[i].ra];
                m_bb[i] = (s[i].rb < nr) && npend[s[i].rb];
            end else begin
                m_da[i] = view(s[i].ra, nr, z0, oreg);
                m_db[i] = view(s[i].rb, nr, z0, oreg);
                m_ba[i] = (s[i].ra < nr) && opend[s[i].ra];
                m_bb[i] = (s[i].rb < nr) && opend[s[i].rb];
            end
        end
        for (int k = 0; k < 32; k++) begin
            m_reg[i][k] = nreg[k];
            m_pend[i][k] = npend[k];
        end
    endtask

    task automatic step();
        apply();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("a.dataout_A", int'(a_da), int'(m_da[0]));
            cmp("a.dataout_B", int'(a_db), int'(m_db[0]));
            cmp("a.busy_A", int'(a_ba), int'(m_ba[0]));
            cmp("a.busy_B", int'(a_bb), int'(m_bb[0]));
            cmp("a.err", int'(a_err), int'(m_err[0]));
            cmp("z.dataout_A", int'(z_da), int'(m_da[1]));
            cmp("z.dataout_B", int'(z_db), int'(m_db[1]));
            cmp("z.busy_A", int'(z_ba), int'(m_ba[1]));
            cmp("z.busy_B", int'(z_bb), int'(m_bb[1]));
            cmp("z.err", int'(z_err), int'(m_err[1]));
        end
    end

    initial begin
        s[0] = idle(); s[1] = idle();
        s[0].rst = 1; s[1].rst = 1;
        step();
        chk_on = 1'b1;
        step();

        // Random activity, then a two-cycle reset must wipe everything.
        for (int c = 0; c < 20; c++) begin
            s[0] = rnd(10, 15, 0); s[1] = rnd(8, 7, 0);
            step();
        end
        s[0] = idle(); s[1] = idle(); s[0].rst = 1; s[1].rst = 1;
        step(); step();
        s[0] = idle(); s[1] = idle();
        for (int r = 0; r < 10; r++) begin
            s[0].rd_en = 1; s[0].ra = r; s[0].rb = 9 - r;
            s[1].rd_en = 1; s[1].ra = r % 8; s[1].rb = 7 - (r % 8);
            step();
            cmp("rst.dataout_A", int'(a_da), 0);
            cmp("rst.dataout_B", int'(a_db), 0);
            cmp("rst.busy_A", int'(a_ba), 0);
        end
        cmp("rst.err", int'(a_err), 0);
        cmp("rst.z_err", int'(z_err), 0);

        // OR2 write then read, one-cycle read latency.
        s[0] = idle(); s[0].wr_en = 1; s[0].sel = 2'b10; s[0].or2 = 8'h05; s[0].wr_addr = 2;
        step();
        s[0] = idle(); s[0].rd_en = 1; s[0].ra = 2;
        step();
        cmp("or2_write_r2", int'(a_da), 8'h05);

        // ALU write then register move, both ports read.
        s[0] = idle(); s[0].wr_en = 1; s[0].sel = 2'b11; s[0].alu = 8'h07; s[0].wr_addr = 3;
        step();
        s[0] = idle(); s[0].wr_en = 1; s[0].sel = 2'b01; s[0].mv_addr = 3; s[0].wr_addr = 5;
        step();
        s[0] = idle(); s[0].rd_en = 1; s[0].ra = 5; s[0].rb = 3;
        step();
        cmp("move_r5", int'(a_da), 8'h07);
        cmp("move_src_r3", int'(a_db), 8'h07);

        // Reservation, then write with a same-cycle read of that register.
        s[0] = idle(); s[0].rsv_en = 1; s[0].rsv_addr = 4;
        step();
        s[0] = idle(); s[0].rd_en = 1; s[0].ra = 4;
        step();
        cmp("rsv_busy_A", int'(a_ba), 1);
        s[0] = idle(); s[0].wr_en = 1; s[0].sel = 2'b11; s[0].alu = 8'h2A; s[0].wr_addr = 4;
        s[0].rd_en = 1; s[0].ra = 4;
        step();
        cmp("wr_rd_same_data", int'(a_da), BYP ? 8'h2A : 8'h00);
        cmp("wr_rd_same_busy", int'(a_ba), BYP ? 0 : 1);
        s[0] = idle(); s[0].rd_en = 1; s[0].ra = 4;
        step();
        cmp("after_wr_data", int'(a_da), 8'h2A);
        cmp("after_wr_busy", int'(a_ba), 0);
        cmp("no_err_yet", int'(a_err), 0);

        // Error cases: no source, then an unmapped destination.
        s[0] = idle(); s[0].wr_en = 1; s[0].sel = 2'b00; s[0].wr_addr = 2;
        step();
        cmp("err_sel_none", int'(a_err), 1);
        s[0] = idle(); s[0].wr_en = 1; s[0].sel = 2'b10; s[0].or2 = 8'h99; s[0].wr_addr = 12;
        step();
        s[0] = idle(); s[0].rd_en = 1; s[0].ra = 2; s[0].rb = 5;
        step();
        cmp("err_r2_kept", int'(a_da), 8'h05);
        cmp("err_r5_kept", int'(a_db), 8'h07);
        s[0] = idle();
        step(); step(); step();
        cmp("err_sticky", int'(a_err), 1);

        // Hardwired r0 on the second instance; rd_en low holds outputs.
        s[1] = idle(); s[1].wr_en = 1; s[1].sel = 2'b11; s[1].alu = 8'hFF; s[1].wr_addr = 0;
        step();
        s[1] = idle(); s[1].rd_en = 1; s[1].ra = 0; s[1].rb = 0;
        step();
        cmp("zr0_read", int'(z_da), 0);
        cmp("zr0_no_err", int'(z_err), 0);
        s[1] = idle(); s[1].wr_en = 1; s[1].sel = 2'b10; s[1].or2 = 8'h33; s[1].wr_addr = 1;
        step();
        s[1] = idle(); s[1].rd_en = 1; s[1].ra = 1; s[1].rb = 1;
        step();
        cmp("z_r1", int'(z_da), 8'h33);
        s[1] = idle(); s[1].rd_en = 0; s[1].ra = 0; s[1].rb = 2;
        step(); step();
        cmp("hold_A", int'(z_da), 8'h33);
        cmp("hold_B", int'(z_db), 8'h33);

        // Long randomized run with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            s[0] = rnd(10, 15, 1); s[1] = rnd(8, 7, 1);
            step();
        end

        s[0] = idle(); s[1] = idle(); s[0].rst = 1; s[1].rst = 1;
        step();
        cmp("final_rst_err", int'(a_err), 0);
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
